mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
- Sequencer for the bit-serial multiplier datapath: accepts an M-bit operand pair on a start/ready handshake.
- Clears the datapath, streams multiplicand `a` LSB-first as 1 bit per cycle, zero-pads, and collects the serial product bits into a 2M-bit result.
- Sits between the MAC control logic and one serial multiplier instance; the datapath is external and connected through the mul_* ports.

Parameters:
- M, 8, operand width; power of two, at least 2.
- LAT, 1, cycles from driving mul_a to the corresponding product bit on mul_o.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request; accepted only when ready=1
- a_in  in  M  multiplicand, streamed serially
- x_in  in  M  multiplier, held parallel on mul_x
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse when product is valid
- product  out  2M  result; holds until the next accepted start
- mul_rst  out  1  datapath clear, active-high
- mul_a  out  1  serial bit to datapath
- mul_x  out  M  parallel operand to datapath
- mul_o  in  1  serial product bit from datapath

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, ready=1, done=0, product=0, mul_a=0, mul_x=0, counter=0, a_reg=0, x_reg=0.
- mul_rst = rst OR (state==CLEAR). This is the only combinational output term.
- IDLE: on start=1, latch a_in into a_reg and x_in into x_reg, clear product, go to CLEAR.
- CLEAR: lasts 1 cycle. mul_rst=1 empties the datapath shift register and carry registers. Counter c=0. Go to RUN.
- RUN: lasts 2M+LAT cycles, with c counting 0..2M+LAT-1.
  - mul_a = a_reg[c] for c<M, else 0.
  - When c>=LAT, the register captures mul_o into product[c-LAT].
  - When c reaches 2M+LAT-1, go to DONE.
- DONE: lasts 1 cycle. done=1, product is final. Go to IDLE. ready returns to 1 on the following cycle.
- mul_x = x_reg, held constant from CLEAR through the end of RUN.
- Latency: start accepted at edge 0 → done high during cycle 2M+LAT+2. For M=8, LAT=1 that is 19 cycles.
- start while ready=0 is ignored; no queueing.
- start asserted on the same edge as rst: rst wins.
- rst mid-operation: returns to IDLE next edge and product is cleared. mul_rst is high during rst, so datapath carries are flushed.
- Back-to-back starts: the new start can be accepted in the cycle after DONE. Every operation passes through CLEAR; carries never leak between operations.
- Arithmetic: unsigned. The product fits in 2M bits; no overflow is possible.

Optional Feature:
- Macro: MULT_SEQ_ACC_EN.
- Defined:
  - Adds an input port acc_clr (1 bit) and a register acc of width 2M+8, which appears as output acc_out.
  - On DONE, acc <= acc + product (zero-extended). Wrap-around is modulo 2^(2M+8).
  - acc_clr sampled with start: acc is zeroed before accumulating that operation.
  - rst zeroes acc.
- Undefined: no acc_clr, acc or acc_out ports and no accumulator logic.

Decomposition:
- Shared package mult_seq_pkg:
  - state enum {IDLE, CLEAR, RUN, DONE} with 2-bit encoding.
  - log2 function for the counter width of 2M+LAT.
- One natural sub-module, mult_seq_capture: a serial-to-parallel 2M-bit shift register with clear and enable.
- The FSM and counter stay in the top module.

Test Plan:
- M=8, a=3, x=5, datapath model attached → done after 19 cycles, product=0x000F.
- a=0xFF, x=0xFF → product=0xFE01. Then a=0x01, x=0x80 back-to-back the cycle after ready → product=0x0080, with no carry leakage from the first operation.
- a=0, x=0xAB → product=0; mul_a is 0 throughout RUN; mul_rst is high exactly 1 cycle after start.
- start pulsed during RUN with a=0x12 → ignored; the first result (a=7, x=9 → 0x003F) completes unchanged.
- rst asserted at c=5 of RUN → next cycle ready=1, product=0, no done. A new run with a=2, x=3 → 0x0006.
- MULT_SEQ_ACC_EN defined: ops 3×5 then 4×4 → acc_out=31. A third op 1×1 with acc_clr=1 → acc_out=1.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared types for the serial multiplier sequencer.
// State encoding and counter-width helper.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// mult_seq_ctrl_if: start/ready request and result bundle.
// master = requester, slave = sequencer.
interface mult_seq_ctrl_if #(
  parameter int M = 8
);

  logic           start;
  logic [M-1:0]   a_in;
  logic [M-1:0]   x_in;
  logic           ready;
  logic           done;
  logic [2*M-1:0] product;

  modport master (
    output start, a_in, x_in,
    input  ready, done, product
  );

  modport slave (
    input  start, a_in, x_in,
    output ready, done, product
  );

endinterface

// File: rtl/mult_seq_capture.sv
// mult_seq_capture: LSB-first serial-to-parallel register.
// After W enabled shifts the first bit sits in q[0].
module mult_seq_capture #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  // shift new bits in at the top so earlier bits drift to the LSB
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= {din, q[W-1:1]};
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencer for one bit-serial multiplier.
// Optional accumulator: define MULT_SEQ_ACC_EN.
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int M   = 8,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  mult_seq_ctrl_if.slave bus,
  output logic         mul_rst,
  output logic         mul_a,
  output logic [M-1:0] mul_x,
  input  logic         mul_o
`ifdef MULT_SEQ_ACC_EN
  ,
  input  logic           acc_clr,
  output logic [2*M+7:0] acc_out
`endif
);

  localparam int CW = log2(2*M + LAT);
  localparam int AW = log2(M);
  localparam logic [CW-1:0] LAST = CW'(2*M + LAT - 1);
  localparam logic [CW-1:0] LATC = CW'(LAT);
  localparam logic [CW-1:0] MC   = CW'(M);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [M-1:0]  a_reg, x_reg;
  logic          accept, cap_en, mul_a_nxt;

  assign accept  = (state == IDLE) && bus.start;
  assign cap_en  = (state == RUN) && (cnt >= LATC);
  assign mul_rst = rst || (state == CLEAR);
  assign mul_x   = x_reg;

  // next state, run counter and next serial bit
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    mul_a_nxt = 1'b0;
    unique case (state)
      IDLE:  if (bus.start) state_nxt = CLEAR;
      CLEAR: state_nxt = RUN;
      RUN: begin
        if (cnt == LAST) state_nxt = DONE;
        else cnt_nxt = cnt + 1'b1;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == RUN && cnt_nxt < MC)
      mul_a_nxt = a_reg[cnt_nxt[AW-1:0]];
  end

  // state, operands and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      a_reg     <= '0;
      x_reg     <= '0;
      mul_a     <= 1'b0;
      bus.ready <= 1'b1;
      bus.done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mul_a     <= mul_a_nxt;
      bus.ready <= (state_nxt == IDLE);
      bus.done  <= (state_nxt == DONE);
      if (accept) begin
        a_reg <= bus.a_in;
        x_reg <= bus.x_in;
      end
    end
  end

  mult_seq_capture #(
    .W (2*M)
  ) u_capture (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (cap_en),
    .din (mul_o),
    .q   (bus.product)
  );

`ifdef MULT_SEQ_ACC_EN
  logic           clr_q;
  logic [2*M+7:0] acc, acc_base;

  assign acc_base = clr_q ? '0 : acc;
  assign acc_out  = acc;

  // fold each finished product into the running sum
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_q <= 1'b0;
      acc   <= '0;
    end else begin
      if (accept) clr_q <= acc_clr;
      if (state == DONE)
        acc <= acc_base + (2*M+8)'(bus.product);
    end
  end
`endif

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: random and directed checks against
// an arithmetic reference and a behavioural datapath.
module tb_mult_seq_ctrl;

  localparam int M = 8;
  localparam int LAT = 1;
  localparam int LATENCY = 2*M + LAT + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         mul_rst, mul_a, mul_o;
  logic [M-1:0] mul_x;
  int           checks = 0;
  int           errors = 0;

  logic [63:0]  dp_acc, dp_an;
  int           dp_n;

  mult_seq_ctrl_if #(.M(M)) bus ();

`ifdef MULT_SEQ_ACC_EN
  logic           acc_clr;
  logic [2*M+7:0] acc_out;
  logic [2*M+7:0] acc_m;
`endif

  mult_seq_ctrl #(
    .M   (M),
    .LAT (LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .mul_rst (mul_rst),
    .mul_a   (mul_a),
    .mul_x   (mul_x),
    .mul_o   (mul_o)
`ifdef MULT_SEQ_ACC_EN
    ,
    .acc_clr (acc_clr),
    .acc_out (acc_out)
`endif
  );

  always #5 clk = ~clk;

  // serial multiplier: bit k of (a bits seen so far) * x,
  // presented one cycle after the k-th a bit
  always @(posedge clk) begin
    if (mul_rst) begin
      dp_acc <= '0;
      dp_n   <= 0;
      mul_o  <= 1'b0;
    end else begin
      dp_an = dp_acc | (64'(mul_a) << dp_n);
      dp_acc <= dp_an;
      dp_n   <= dp_n + 1;
      mul_o  <= 1'((dp_an * 64'(mul_x)) >> dp_n);
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 64'(bus.ready), 64'd1);
  endtask

  // one operation; inj>1 pulses start with a=0x12 in that cycle
  task automatic run_op(input logic [M-1:0] a,
                        input logic [M-1:0] x,
                        input bit clr,
                        input int inj);
    int  n, rst_hi, ones, rdy_hi;
    bit  got;
    logic [2*M-1:0] exp;
    exp = (2*M)'(a) * (2*M)'(x);
    wait_ready();
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.x_in  = x;
`ifdef MULT_SEQ_ACC_EN
    acc_clr = clr;
`endif
    n = 0; rst_hi = 0; ones = 0; rdy_hi = 0; got = 0;
    while (n < LATENCY + 10 && !got) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1)
        check("clear_pulse", 64'(mul_rst), 64'd1);
      rst_hi += int'(mul_rst);
      ones   += int'(mul_a);
      rdy_hi += int'(bus.ready);
      if (bus.done === 1'b1) got = 1;
      if (n == 1) begin
        bus.start = 1'b0;
        bus.a_in  = M'($urandom);
        bus.x_in  = M'($urandom);
`ifdef MULT_SEQ_ACC_EN
        acc_clr = 1'b0;
`endif
      end
      if (n == inj) begin
        bus.start = 1'b1;
        bus.a_in  = 8'h12;
      end
      if (n == inj + 1) bus.start = 1'b0;
    end
    check("done_seen", 64'(got), 64'd1);
    check("latency", 64'(n), 64'(LATENCY));
    check("product", 64'(bus.product), 64'(exp));
    check("mul_rst_cycles", 64'(rst_hi), 64'd1);
    check("mul_a_ones", 64'(ones), 64'($countones(a)));
    check("ready_busy", 64'(rdy_hi), 64'd0);
    @(negedge clk);
    check("done_pulse", 64'(bus.done), 64'd0);
    check("ready_back", 64'(bus.ready), 64'd1);
    check("product_hold", 64'(bus.product), 64'(exp));
`ifdef MULT_SEQ_ACC_EN
    if (clr) acc_m = '0;
    acc_m = acc_m + (2*M+8)'(exp);
    check("acc_out", 64'(acc_out), 64'(acc_m));
`endif
  endtask

  initial begin
    int  n, seen;
    logic [M-1:0] ra, rx;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.x_in  = '0;
`ifdef MULT_SEQ_ACC_EN
    acc_clr = 1'b0;
    acc_m   = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_product", 64'(bus.product), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_x", 64'(mul_x), 64'd0);
    check("rst_mul_rst", 64'(mul_rst), 64'd1);
    bus.start = 1'b1;
    bus.a_in  = 8'h55;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_wins_ready", 64'(bus.ready), 64'd1);
    check("rst_wins_clear", 64'(mul_rst), 64'd0);

    run_op(8'd3, 8'd5, 1'b0, 0);
    run_op(8'd4, 8'd4, 1'b0, 0);
`ifdef MULT_SEQ_ACC_EN
    check("acc_31", 64'(acc_out), 64'd31);
`endif
    run_op(8'd1, 8'd1, 1'b1, 0);
`ifdef MULT_SEQ_ACC_EN
    check("acc_clr_1", 64'(acc_out), 64'd1);
`endif
    run_op(8'hFF, 8'hFF, 1'b0, 0);
    run_op(8'h01, 8'h80, 1'b0, 0);
    run_op(8'h00, 8'hAB, 1'b0, 0);
    run_op(8'd7, 8'd9, 1'b0, 6);

    wait_ready();
    bus.start = 1'b1;
    bus.a_in  = 8'hC3;
    bus.x_in  = 8'h5A;
    n = 0;
    while (n < 7) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", 64'(bus.ready), 64'd1);
    check("abort_product", 64'(bus.product), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_mul_rst", 64'(mul_rst), 64'd1);
    rst = 1'b0;
`ifdef MULT_SEQ_ACC_EN
    acc_m = '0;
    check("abort_acc", 64'(acc_out), 64'd0);
`endif
    seen = 0;
    repeat (LATENCY + 5) begin
      @(negedge clk);
      seen += int'(bus.done);
    end
    check("abort_no_done", 64'(seen), 64'd0);
    run_op(8'd2, 8'd3, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      ra = M'($urandom);
      rx = M'($urandom);
      run_op(ra, rx, ($urandom_range(3) == 0),
             ($urandom_range(1) == 1) ?
               int'($urandom_range(17, 3)) : 0);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
